uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL have parameter CLK_FREQ, default 50_000_000, meaning the sys_clk frequency in Hz.
REQ-002 The block SHALL have parameter BAUD, default 9600, meaning the line bit rate.
REQ-003 The block SHALL derive BIT_CNT = CLK_FREQ/BAUD (integer division) and HALF_CNT = BIT_CNT/2.
REQ-004 The block SHALL have port sys_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 The block SHALL have port rx, input, 1 bit: asynchronous serial line, idle high, 8N1 framing, LSB first.
REQ-007 The block SHALL have port data_out, output, 8 bits: the last correctly received byte.
REQ-008 The block SHALL have port rx_done, output, 1 bit: one-cycle pulse when data_out is updated.
REQ-009 The block SHALL have port frame_err, output, 1 bit: one-cycle pulse when a stop bit samples low.
REQ-010 The block SHALL have port busy_flag, output, 1 bit: high while a frame is being received.

Function
REQ-011 rx SHALL pass through a 2-flop synchronizer; a third flop SHALL provide the previous synchronized value for edge detection.
REQ-012 A start edge SHALL be a synchronized 1->0 transition seen in state IDLE; edges in any other state SHALL be ignored.
REQ-013 The FSM SHALL have states IDLE, START, DATA and STOP.
REQ-014 IDLE->START SHALL occur on a start edge; the baud counter SHALL clear to 0 and the bit index SHALL clear to 0.
REQ-015 The baud counter SHALL count 0..BIT_CNT-1 and wrap to 0 in START, DATA and STOP; it SHALL be held at 0 in IDLE.
REQ-016 Each sample point SHALL be the cycle where the baud counter equals HALF_CNT-1.
REQ-017 In START at the sample point: synchronized rx=0 SHALL go to DATA; rx=1 (glitch) SHALL return to IDLE with no output pulse.
REQ-018 In DATA, each sample point SHALL shift the synchronized rx into bit[index] of a shift register (LSB first).
REQ-019 DATA SHALL go to STOP after the 8th sample (index 7).
REQ-020 In STOP at the sample point, rx=1 SHALL load the shift register into data_out and pulse rx_done for exactly 1 cycle on the next clock.
REQ-021 In STOP at the sample point, rx=0 SHALL leave data_out unchanged and pulse frame_err for exactly 1 cycle on the next clock.
REQ-022 After either STOP outcome the FSM SHALL go to IDLE at mid-stop-bit, so a new start edge at the following bit boundary is accepted (back-to-back frames).
REQ-023 busy_flag SHALL be 1 in START, DATA and STOP and 0 in IDLE, registered with the state.
REQ-024 rx_done and frame_err SHALL never be high in the same cycle.
REQ-025 data_out SHALL hold its value between frames and SHALL NOT change on glitch or frame error.
REQ-026 Latency from the detected start edge to rx_done SHALL be 9*BIT_CNT + HALF_CNT cycles, plus or minus 1.
REQ-027 A line held low continuously (break condition) SHALL produce frame_err once, then stay in IDLE until a new 1->0 edge occurs.

Reset
REQ-028 While rst_n=0, the block SHALL force: state IDLE, counters 0, shift register 0, data_out 8'h00, rx_done 0, frame_err 0, busy_flag 0, synchronizer flops 1.
REQ-029 Reset asserted mid-frame SHALL abort the frame immediately with no pulse; after release the block SHALL wait for a fresh start edge.

Verification (bench uses CLK_FREQ=50_000_000 and BAUD=115200, giving BIT_CNT=434; sys_clk period 20 ns; rst_n released at 20 ns)
REQ-030 Send 0x55 as a valid 8N1 frame -> data_out=8'h55, one rx_done pulse, busy_flag high for the frame, frame_err stays 0.
REQ-031 Send 0xB3 immediately followed by 0x00 with no idle gap -> two rx_done pulses, data_out=8'hB3 then 8'h00.
REQ-032 Apply a 2 us low glitch on an idle line -> no rx_done, no frame_err, busy_flag returns to 0 after about HALF_CNT cycles, data_out unchanged.
REQ-033 Send 0xA5 with the stop bit driven low -> one frame_err pulse, no rx_done, data_out keeps its previous value.
REQ-034 Assert rst_n=0 during bit 4 of 0x3C, release it, then send 0xC3 -> no pulse for the aborted frame; rx_done with data_out=8'hC3.
REQ-035 Send 0x55 at +2% and at -2% baud error -> data_out=8'h55 in both cases.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver, LSB first, mid-bit sampling.
// Ports: sys_clk, rst_n (async low), rx -> data_out, rx_done, frame_err, busy_flag.
module uart_rx #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 9600
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       rx_done,
  output logic       frame_err,
  output logic       busy_flag
);

  localparam int BIT_CNT  = CLK_FREQ / BAUD;
  localparam int HALF_CNT = BIT_CNT / 2;
  localparam int CW       = $clog2(BIT_CNT + 1);

  localparam logic [CW-1:0] CNT_MAX = CW'(BIT_CNT - 1);
  localparam logic [CW-1:0] CNT_SMP = CW'(HALF_CNT - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic          rx_m;
  logic          rx_s;
  logic          rx_p;
  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          start_edge;
  logic          sample;

  assign start_edge = rx_p & ~rx_s;
  assign sample     = (baud_cnt == CNT_SMP);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start_edge) state_nxt = START;
      START: if (sample) state_nxt = rx_s ? IDLE : DATA;
      DATA:  if (sample && bit_idx == 3'd7) state_nxt = STOP;
      STOP:  if (sample) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_m      <= 1'b1;
      rx_s      <= 1'b1;
      rx_p      <= 1'b1;
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_idx   <= 3'd0;
      shift     <= 8'h00;
      data_out  <= 8'h00;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
      busy_flag <= 1'b0;
    end else begin
      rx_m      <= rx;
      rx_s      <= rx_m;
      rx_p      <= rx_s;
      state     <= state_nxt;
      busy_flag <= (state_nxt != IDLE);
      rx_done   <= 1'b0;
      frame_err <= 1'b0;

      // Counter idles at 0, so a start edge begins a fresh bit period.
      if (state == IDLE || state_nxt == IDLE) begin
        baud_cnt <= '0;
      end else if (baud_cnt == CNT_MAX) begin
        baud_cnt <= '0;
      end else begin
        baud_cnt <= baud_cnt + 1'b1;
      end

      if (state == IDLE) begin
        bit_idx <= 3'd0;
      end

      if (state == DATA && sample) begin
        shift[bit_idx] <= rx_s;
        bit_idx        <= bit_idx + 3'd1;
      end

      if (state == STOP && sample) begin
        if (rx_s) begin
          data_out <= shift;
          rx_done  <= 1'b1;
        end else begin
          frame_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames for uart_rx at 115200 baud from 50 MHz.
// Expected bytes/errors are queued on send and popped on each DUT pulse.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int BT      = 8680;
  localparam int BT_FAST = 8510;
  localparam int BT_SLOW = 8857;

  typedef struct packed {
    logic       err;
    logic [7:0] data;
  } exp_t;

  logic       sys_clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic [7:0] data_out;
  logic       rx_done;
  logic       frame_err;
  logic       busy_flag;

  int         compared   = 0;
  int         mismatched = 0;
  exp_t       q[$];
  logic [7:0] last = 8'h00;
  time        t_fall;
  time        t_done = 0;
  int         lat;

  uart_rx #(
    .CLK_FREQ(50_000_000),
    .BAUD    (115200)
  ) dut (
    .sys_clk  (sys_clk),
    .rst_n    (rst_n),
    .rx       (rx),
    .data_out (data_out),
    .rx_done  (rx_done),
    .frame_err(frame_err),
    .busy_flag(busy_flag)
  );

  always #10 sys_clk = ~sys_clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_ok(input logic [7:0] b);
    q.push_back('{err: 1'b0, data: b});
    last = b;
  endtask

  task automatic expect_err();
    q.push_back('{err: 1'b1, data: last});
  endtask

  task automatic send(input logic [7:0] b, input logic stop,
                      input int bt, input bit chk);
    rx = 1'b0;
    #(bt);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      if (chk && i == 3) begin
        #(bt / 2);
        check("busy_mid_frame", {31'b0, busy_flag}, 1);
        #(bt - bt / 2);
      end else begin
        #(bt);
      end
    end
    rx = stop;
    #(bt);
    rx = 1'b1;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (q.size() != 0 && n < 20000) begin
      @(negedge sys_clk);
      n++;
    end
    check(tag, q.size(), 0);
  endtask

  always @(negedge sys_clk) begin
    if (rst_n && (rx_done || frame_err)) begin
      exp_t e;
      check("pulse_exclusive", {31'b0, rx_done & frame_err}, 0);
      check("pulse_expected", {31'b0, q.size() != 0}, 1);
      if (q.size() != 0) begin
        e = q.pop_front();
        check("pulse_kind", {31'b0, frame_err}, {31'b0, e.err});
        check("data_out_at_pulse", {24'b0, data_out}, {24'b0, e.data});
      end
      if (rx_done && t_done == 0) t_done = $time;
    end
  end

  initial begin
    rx    = 1'b1;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #8;
    check("rst_data_out", {24'b0, data_out}, 0);
    check("rst_rx_done", {31'b0, rx_done}, 0);
    check("rst_frame_err", {31'b0, frame_err}, 0);
    check("rst_busy", {31'b0, busy_flag}, 0);
    #11 rst_n = 1'b1;
    repeat (5) @(negedge sys_clk);
    #3;

    // valid 0x55 plus latency measurement
    expect_ok(8'h55);
    t_fall = $time;
    send(8'h55, 1'b1, BT, 1'b1);
    drain("drain_55");
    lat = int'((t_done - t_fall) / 20);
    check("latency_ok", {31'b0, lat >= 4122 && lat <= 4127}, 1);
    check("busy_after_55", {31'b0, busy_flag}, 0);
    #(BT);

    // back-to-back 0xB3, 0x00
    expect_ok(8'hB3);
    expect_ok(8'h00);
    send(8'hB3, 1'b1, BT, 1'b0);
    send(8'h00, 1'b1, BT, 1'b0);
    drain("drain_b3_00");
    #(BT);

    // 2 us glitch
    rx = 1'b0;
    #1000;
    check("busy_in_glitch", {31'b0, busy_flag}, 1);
    #1000;
    rx = 1'b1;
    repeat (300) @(negedge sys_clk);
    #3;
    check("busy_after_glitch", {31'b0, busy_flag}, 0);
    check("data_after_glitch", {24'b0, data_out}, 0);
    check("no_pulse_glitch", q.size(), 0);
    #(BT);

    // 0xA5 with low stop bit
    expect_err();
    send(8'hA5, 1'b0, BT, 1'b0);
    drain("drain_a5_err");
    check("data_after_err", {24'b0, data_out}, 0);
    #(BT);

    // reset during bit 4 of 0x3C
    begin
      logic [7:0] b;
      b = 8'h3C;
      rx = 1'b0;
      #(BT);
      for (int i = 0; i < 4; i++) begin
        rx = b[i];
        #(BT);
      end
      rx = b[4];
      #(BT / 2);
    end
    rst_n = 1'b0;
    rx    = 1'b1;
    last  = 8'h00;
    #100;
    check("abort_busy", {31'b0, busy_flag}, 0);
    check("abort_rx_done", {31'b0, rx_done}, 0);
    check("abort_data", {24'b0, data_out}, 0);
    #(2 * BT);
    rst_n = 1'b1;
    #(BT);
    expect_ok(8'hC3);
    send(8'hC3, 1'b1, BT, 1'b0);
    drain("drain_c3");
    check("data_c3", {24'b0, data_out}, 32'hC3);
    #(BT);

    // +/-2 % baud error
    expect_ok(8'h55);
    send(8'h55, 1'b1, BT_FAST, 1'b0);
    drain("drain_fast");
    check("data_fast", {24'b0, data_out}, 32'h55);
    #(BT);
    expect_ok(8'h00);
    send(8'h00, 1'b1, BT, 1'b0);
    drain("drain_mid00");
    #(BT);
    expect_ok(8'h55);
    send(8'h55, 1'b1, BT_SLOW, 1'b0);
    drain("drain_slow");
    check("data_slow", {24'b0, data_out}, 32'h55);
    #(BT);

    // break: single frame_err then silent
    expect_err();
    rx = 1'b0;
    #(12 * BT);
    drain("drain_break");
    #(3 * BT);
    check("busy_in_break", {31'b0, busy_flag}, 0);
    rx = 1'b1;
    #(BT);
    expect_ok(8'h81);
    send(8'h81, 1'b1, BT, 1'b0);
    drain("drain_81");
    check("data_81", {24'b0, data_out}, 32'h81);
    #(BT);
    check("queue_final", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
